fetch_linebuffer_mp: RTL and testbench

Parametrised, multi-entry, multi-port instruction line buffer between the fetch stage and the I-cache. It holds `NUM_ENTRIES` fully-associative 256-bit lines and serves up to `NUM_PORTS` same-cycle fetch reads from any resident line. It keeps at most one refill outstanding, and on a miss in any port it fetches the missing line, including the line a later port crosses into. Refill data is bypassed to every port whose line matches in the response cycle.

---
 rtl/fetch_linebuffer_mp_pkg.sv | 10 +
 rtl/fetch_linebuffer_mp_port_lookup.sv | 41 ++++
 rtl/fetch_linebuffer_mp.sv | 174 +++++++++++++++++
 tb/tb_fetch_linebuffer_mp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_linebuffer_mp_pkg.sv
// Shared types for the multi-port fetch line buffer.
package types;
    localparam int LB_TAG_BITS = 27;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } lb_state_t;
endpackage

// File: rtl/fetch_linebuffer_mp_port_lookup.sv
// Per-port associative lookup: compares the port's line tag against every
// resident entry and returns the addressed word of the matching line.
module lb_port_lookup
    import types::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int LINE_BITS   = 256,
    parameter int WIDX        = 3
) (
    input  logic [NUM_ENTRIES*LB_TAG_BITS-1:0] tags,
    input  logic [NUM_ENTRIES-1:0]             valid,
    input  logic [NUM_ENTRIES*LINE_BITS-1:0]   data,
    input  logic [LB_TAG_BITS-1:0]             line_tag,
    input  logic [WIDX-1:0]                    word_idx,
    output logic                               hit,
    output logic [NUM_ENTRIES-1:0]             hit_vec,
    output logic [31:0]                        word
);
    logic [LINE_BITS-1:0] line_sel;

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
            assign hit_vec[gi] = valid[gi] &&
                (tags[gi*LB_TAG_BITS +: LB_TAG_BITS] == line_tag);
        end
    endgenerate

    assign hit = |hit_vec;

    // Tags are unique, so an OR of the masked lines is a one-hot select.
    always_comb begin
        line_sel = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (hit_vec[e]) begin
                line_sel = line_sel | data[e*LINE_BITS +: LINE_BITS];
            end
        end
    end

    assign word = line_sel[{word_idx, 5'b00000} +: 32];
endmodule

// File: rtl/fetch_linebuffer_mp.sv
// Fully-associative multi-port instruction line buffer with a single
// outstanding I-cache refill and same-cycle refill bypass.
module fetch_linebuffer_mp
    import types::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int NUM_PORTS   = 2,
    parameter int LINE_BITS   = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS*32-1:0]    fetch_addr,
    input  logic [NUM_PORTS*4-1:0]     fetch_rmask,
    output logic [NUM_PORTS*32-1:0]    fetch_rdata,
    output logic [NUM_PORTS-1:0]       fetch_resp,
    input  logic                       invalidate,
    output logic [31:0]                cache_addr,
    output logic [3:0]                 cache_rmask,
    input  logic [LINE_BITS-1:0]       cache_rdata_line,
    input  logic                       cache_resp
);
    localparam int WORDS    = LINE_BITS / 32;
    localparam int WIDX     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_BITS = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    lb_state_t                 state_reg;
    logic [LB_TAG_BITS-1:0]    req_tag_reg;
    logic [PTR_BITS-1:0]       rr_ptr_reg;
    logic [NUM_ENTRIES-1:0]    valid_reg;
    logic [LB_TAG_BITS-1:0]    tag_reg  [NUM_ENTRIES];
    logic [LINE_BITS-1:0]      data_reg [NUM_ENTRIES];

    logic [NUM_ENTRIES*LB_TAG_BITS-1:0] tags_flat;
    logic [NUM_ENTRIES*LINE_BITS-1:0]   data_flat;

    logic [NUM_PORTS-1:0]      active;
    logic [NUM_PORTS-1:0]      lk_hit;
    logic [NUM_PORTS-1:0]      miss;
    logic [NUM_PORTS-1:0]      bypass;
    logic [NUM_ENTRIES-1:0]    port_vec [NUM_PORTS];
    logic [31:0]               lk_word  [NUM_PORTS];

    logic                      any_miss;
    logic [LB_TAG_BITS-1:0]    miss_tag;
    logic                      has_invalid;
    logic [PTR_BITS-1:0]       victim;
    logic                      fill_en;

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_flat
            assign tags_flat[gi*LB_TAG_BITS +: LB_TAG_BITS] = tag_reg[gi];
            assign data_flat[gi*LINE_BITS +: LINE_BITS]     = data_reg[gi];
        end

        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [LB_TAG_BITS-1:0] port_tag;
            logic [WIDX-1:0]        word_idx;

            assign port_tag = fetch_addr[gi*32+5 +: LB_TAG_BITS];
            assign word_idx = fetch_addr[gi*32+2 +: WIDX];
            assign active[gi] = |fetch_rmask[gi*4 +: 4];

            lb_port_lookup #(
                .NUM_ENTRIES (NUM_ENTRIES),
                .LINE_BITS   (LINE_BITS),
                .WIDX        (WIDX)
            ) u_lookup (
                .tags     (tags_flat),
                .valid    (valid_reg),
                .data     (data_flat),
                .line_tag (port_tag),
                .word_idx (word_idx),
                .hit      (lk_hit[gi]),
                .hit_vec  (port_vec[gi]),
                .word     (lk_word[gi])
            );

            assign miss[gi]   = active[gi] && !(|port_vec[gi]);
            assign bypass[gi] = active[gi] && cache_resp && (state_reg == BUSY) &&
                                (req_tag_reg == port_tag);
            assign fetch_resp[gi] = !invalidate && ((active[gi] && lk_hit[gi]) || bypass[gi]);
            assign fetch_rdata[gi*32 +: 32] = lk_hit[gi] ? lk_word[gi] :
                cache_rdata_line[{word_idx, 5'b00000} +: 32];
        end
    endgenerate

    // Oldest (lowest-index) missing port wins the single refill slot.
    always_comb begin
        any_miss = 1'b0;
        miss_tag = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (miss[p]) begin
                any_miss = 1'b1;
                miss_tag = fetch_addr[p*32+5 +: LB_TAG_BITS];
            end
        end
    end

    always_comb begin
        has_invalid = 1'b0;
        victim      = rr_ptr_reg;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            if (!valid_reg[e]) begin
                has_invalid = 1'b1;
                victim      = PTR_BITS'(e);
            end
        end
    end

    assign fill_en = (state_reg == BUSY) && cache_resp && !invalidate;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            req_tag_reg <= '0;
            rr_ptr_reg  <= '0;
            valid_reg   <= '0;
            cache_addr  <= '0;
            cache_rmask <= 4'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!invalidate && any_miss) begin
                        state_reg   <= BUSY;
                        req_tag_reg <= miss_tag;
                        cache_addr  <= {miss_tag, 5'b00000};
                        cache_rmask <= 4'hF;
                    end
                end
                BUSY: begin
                    if (cache_resp) begin
                        state_reg   <= IDLE;
                        cache_addr  <= '0;
                        cache_rmask <= 4'h0;
                    end else if (invalidate) begin
                        state_reg   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cache_resp) begin
                        state_reg   <= IDLE;
                        cache_addr  <= '0;
                        cache_rmask <= 4'h0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    cache_addr  <= '0;
                    cache_rmask <= 4'h0;
                end
            endcase

            if (fill_en) begin
                valid_reg[victim] <= 1'b1;
                if (!has_invalid) begin
                    rr_ptr_reg <= (rr_ptr_reg == PTR_BITS'(NUM_ENTRIES - 1)) ?
                                  '0 : rr_ptr_reg + 1'b1;
                end
            end

            if (invalidate) begin
                valid_reg <= '0;
            end
        end
    end

    // Line storage carries no reset; residency is governed by valid_reg.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_reg[victim]  <= req_tag_reg;
            data_reg[victim] <= cache_rdata_line;
        end
    end
endmodule

// File: tb/tb_fetch_linebuffer_mp.sv
// Bench for fetch_linebuffer_mp: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural line-buffer model.
module tb_fetch_linebuffer_mp;
    localparam int NE = 4;
    localparam int NP = 2;
    localparam int LB = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*32-1:0]  fetch_addr;
    logic [NP*4-1:0]   fetch_rmask;
    logic [NP*32-1:0]  fetch_rdata;
    logic [NP-1:0]     fetch_resp;
    logic              invalidate;
    logic [31:0]       cache_addr;
    logic [3:0]        cache_rmask;
    logic [LB-1:0]     cache_rdata_line;
    logic              cache_resp;

    int checks = 0;
    int errors = 0;

    localparam int S_IDLE = 0, S_BUSY = 1, S_DRAIN = 2;
    int          m_state;
    logic [26:0] m_req_tag;
    int          m_rr;
    bit          m_valid [NE];
    logic [26:0] m_tag   [NE];
    int          m_since;

    fetch_linebuffer_mp #(.NUM_ENTRIES(NE), .NUM_PORTS(NP), .LINE_BITS(LB)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_addr       (fetch_addr),
        .fetch_rmask      (fetch_rmask),
        .fetch_rdata      (fetch_rdata),
        .fetch_resp       (fetch_resp),
        .invalidate       (invalidate),
        .cache_addr       (cache_addr),
        .cache_rmask      (cache_rmask),
        .cache_rdata_line (cache_rdata_line),
        .cache_resp       (cache_resp)
    );

    always #5 clk = ~clk;

    // Backing instruction memory: every word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = 32'(a >> 2);
        return (w * 32'h9E37_79B9) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [LB-1:0] line_of(input logic [26:0] t);
        logic [LB-1:0] l;
        for (int w = 0; w < LB / 32; w++) l[w*32 +: 32] = mem_word({t, 5'b0} + 32'(w * 4));
        return l;
    endfunction

    function automatic bit resident(input logic [26:0] t);
        for (int e = 0; e < NE; e++) if (m_valid[e] && m_tag[e] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_req_tag = '0; m_rr = 0; m_since = 0;
        for (int e = 0; e < NE; e++) begin m_valid[e] = 1'b0; m_tag[e] = '0; end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < NP; p++) begin
            logic [31:0] a;
            bit act, hit, byp, eresp;
            a     = fetch_addr[p*32 +: 32];
            act   = |fetch_rmask[p*4 +: 4];
            hit   = act && resident(a[31:5]);
            byp   = act && cache_resp && m_state == S_BUSY && m_req_tag == a[31:5];
            eresp = !invalidate && (hit || byp);
            check($sformatf("resp%0d@%h", p, a), 32'(fetch_resp[p]), 32'(eresp));
            if (eresp) check($sformatf("rdata%0d@%h", p, a), fetch_rdata[p*32 +: 32], mem_word(a));
        end
        check("cache_rmask", 32'(cache_rmask), (m_state != S_IDLE) ? 32'hF : 32'h0);
        check("cache_addr", cache_addr, (m_state != S_IDLE) ? {m_req_tag, 5'b0} : 32'h0);
    endtask

    task automatic model_fill(input logic [26:0] t);
        int v;
        v = -1;
        for (int e = 0; e < NE; e++) if (!m_valid[e] && v < 0) v = e;
        if (v < 0) begin v = m_rr; m_rr = (m_rr + 1) % NE; end
        m_valid[v] = 1'b1;
        m_tag[v]   = t;
    endtask

    task automatic model_update();
        bit any_miss;
        logic [26:0] mt;
        if (rst) begin model_reset(); return; end
        any_miss = 1'b0; mt = '0;
        for (int p = NP - 1; p >= 0; p--) begin
            logic [31:0] a;
            a = fetch_addr[p*32 +: 32];
            if ((|fetch_rmask[p*4 +: 4]) && !resident(a[31:5])) begin any_miss = 1'b1; mt = a[31:5]; end
        end
        case (m_state)
            S_IDLE: if (!invalidate && any_miss) begin m_state = S_BUSY; m_req_tag = mt; m_since = 0; end
            S_BUSY: begin
                m_since++;
                if (cache_resp) begin
                    if (!invalidate) model_fill(m_req_tag);
                    m_state = S_IDLE;
                end else if (invalidate) m_state = S_DRAIN;
            end
            default: begin
                m_since++;
                if (cache_resp) m_state = S_IDLE;
            end
        endcase
        if (invalidate) for (int e = 0; e < NE; e++) m_valid[e] = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic [31:0] a0, input logic [3:0] m0,
                         input logic [31:0] a1, input logic [3:0] m1);
        fetch_addr  = {a1, a0};
        fetch_rmask = {m1, m0};
    endtask

    task automatic respond(input bit on);
        cache_resp       = on;
        cache_rdata_line = line_of(m_req_tag);
    endtask

    task automatic fill_line(input logic [31:0] a);
        drive(a, 4'hF, 32'h0, 4'h0);
        tick(); tick();
        respond(1'b1); tick(); respond(1'b0);
        $display("fill line %h done", a);
    endtask

    initial begin
        rst = 1'b1; invalidate = 1'b0; cache_resp = 1'b0; cache_rdata_line = '0;
        drive(32'h0, 4'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick();
        rst = 1'b0;
        check("reset_rmask", 32'(cache_rmask), 32'h0);
        check("reset_addr", cache_addr, 32'h0);

        // Cold miss on two adjacent words of one line.
        $display("step: cold miss 0x1000/0x1004");
        drive(32'h1000, 4'hF, 32'h1004, 4'hF);
        tick();
        check("cold_req_addr", cache_addr, 32'h0000_1000);
        check("cold_req_rmask", 32'(cache_rmask), 32'hF);
        tick(); tick();
        respond(1'b1); tick(); respond(1'b0);
        tick();

        // Line crossing: port 0 hits the last word, port 1 needs the next line.
        $display("step: line crossing 0x101C/0x1020");
        drive(32'h101C, 4'hF, 32'h1020, 4'hF);
        tick();
        check("cross_req_addr", cache_addr, 32'h0000_1020);
        tick();
        respond(1'b1); tick(); respond(1'b0);
        tick();

        // Round-robin replacement once all four entries are full.
        $display("step: replacement");
        rst = 1'b1; tick(); rst = 1'b0;
        fill_line(32'h0); fill_line(32'h20); fill_line(32'h40); fill_line(32'h60); fill_line(32'h80);
        drive(32'h0, 4'hF, 32'h20, 4'hF);
        tick();
        check("evict_req_addr", cache_addr, 32'h0);
        tick();
        respond(1'b1); tick(); respond(1'b0);
        drive(32'h20, 4'hF, 32'h0, 4'h0);
        tick();
        check("evict1_req_addr", cache_addr, 32'h20);
        tick(); respond(1'b1); tick(); respond(1'b0);

        // Invalidate while a refill is in flight.
        $display("step: invalidate while busy 0x2000");
        drive(32'h2000, 4'hF, 32'h2004, 4'h0);
        tick();
        invalidate = 1'b1; tick(); invalidate = 1'b0;
        check("drain_hold_addr", cache_addr, 32'h2000);
        tick();
        respond(1'b1); tick(); respond(1'b0);
        tick();
        check("rerequest_addr", cache_addr, 32'h2000);
        tick(); respond(1'b1); tick(); respond(1'b0);

        // Invalidate in the same cycle as the refill response.
        $display("step: invalidate with resp 0x3000");
        drive(32'h3000, 4'hF, 32'h0, 4'h0);
        tick(); tick();
        invalidate = 1'b1; respond(1'b1); tick(); invalidate = 1'b0; respond(1'b0);
        tick();
        check("inv_resp_rerequest", cache_addr, 32'h3000);
        tick(); respond(1'b1); tick(); respond(1'b0);

        // Reset while busy, then a stale response arrives.
        $display("step: reset while busy 0x4000");
        drive(32'h4000, 4'hF, 32'h0, 4'h0);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_busy_rmask", 32'(cache_rmask), 32'h0);
        drive(32'h4000, 4'h0, 32'h0, 4'h0);
        cache_resp = 1'b1; cache_rdata_line = line_of(27'(32'h4000 >> 5)); tick(); cache_resp = 1'b0;
        drive(32'h4000, 4'hF, 32'h0, 4'h0);
        tick();
        check("stale_no_fill", cache_addr, 32'h4000);
        tick(); respond(1'b1); tick(); respond(1'b0);

        // Random traffic over a small pool of lines to force replacement.
        $display("step: random traffic");
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a0, a1;
            a0 = 32'h8000 + 32'($urandom_range(0, 5)) * 32 + 32'($urandom_range(0, 7)) * 4;
            a1 = ($urandom_range(0, 2) == 0) ?
                 32'h8000 + 32'($urandom_range(0, 5)) * 32 + 32'($urandom_range(0, 7)) * 4 : a0 + 4;
            drive(a0, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'(($urandom_range(0, 1) == 0) ? 4'hF : 4'h1),
                  a1, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'hF);
            rst        = ($urandom_range(0, 199) == 0);
            invalidate = ($urandom_range(0, 24) == 0);
            if (m_state != S_IDLE) begin
                cache_resp       = (m_since >= 1) && ($urandom_range(0, 2) == 0);
                cache_rdata_line = line_of(m_req_tag);
            end else begin
                cache_resp       = ($urandom_range(0, 19) == 0);
                cache_rdata_line = line_of(27'($urandom));
            end
            tick();
        end
        rst = 1'b0; invalidate = 1'b0; cache_resp = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
